mem_access_stage: RTL and testbench
===================================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter: TIMEOUT, 255, max cycles waited for dmem_ack before forced completion (1..255).
REQ-002 clock  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low; reset=0 clears all state immediately.
REQ-004 mem_to_reg_in, reg_write_in, mem_read_in, mem_write_in, beq_instruction_in  in  1 each  EX/MEM control fields.
REQ-005 alu_result_in  in  32  EX/MEM ALU result (memory address for loads/stores).
REQ-006 mux2_result_in  in  32  EX/MEM store data.
REQ-007 reg_rd_in  in  5  EX/MEM destination register; flag_beq_in  in  1  EX/MEM zero flag.
REQ-008 dmem_req  out  1  data-memory request; dmem_we  out  1  1=write, 0=read.
REQ-009 dmem_addr  out  32; dmem_wdata  out  32; dmem_rdata  in  32; dmem_ack  in  1  one-cycle completion pulse.
REQ-010 stall_out  out  1  freezes PC, IF/ID, ID/EX and EX/MEM while high.
REQ-011 pc_src_out  out  1  branch taken.
REQ-012 mem_to_reg_out, reg_write_out  out  1 each; read_data_out, alu_result_out  out  32 each; reg_rd_out  out  5: MEM/WB register.
REQ-013 ex_mem_reg_rd  out  5; ex_mem_reg_write  out  1; alu_ex_mem  out  32: forwarding source from EX/MEM.
REQ-014 mem_wb_reg_rd  out  5; mem_wb_reg_write  out  1; alu_data_mem_wb  out  32: forwarding source from MEM/WB.
REQ-015 mem_error_out  out  1  sticky timeout flag.

Function
REQ-016 pc_src_out = beq_instruction_in AND flag_beq_in, combinational, independent of FSM state.
REQ-017 ex_mem_reg_rd=reg_rd_in, ex_mem_reg_write=reg_write_in, alu_ex_mem=alu_result_in, combinational.
REQ-018 mem_wb_reg_rd=reg_rd_out, mem_wb_reg_write=reg_write_out; alu_data_mem_wb = mem_to_reg_out ? read_data_out : alu_result_out.
REQ-019 access = mem_read_in OR mem_write_in; if both set, treat as write.
REQ-020 FSM states IDLE, BUSY; IDLE with access -> BUSY next edge; IDLE without access stays IDLE.
REQ-021 BUSY -> IDLE on edge where dmem_ack=1 or wait counter = TIMEOUT; else stay BUSY.
REQ-022 dmem_req=1 in IDLE-with-access and throughout BUSY; 0 otherwise.
REQ-023 dmem_addr=alu_result_in, dmem_wdata=mux2_result_in, dmem_we=mem_write_in, combinational; stable while stalled since EX/MEM is frozen.
REQ-024 stall_out = (IDLE AND access) OR (BUSY AND NOT dmem_ack AND counter != TIMEOUT).
REQ-025 Wait counter 8-bit: cleared in IDLE, increments each BUSY cycle, saturates at TIMEOUT.
REQ-026 dmem_ack in IDLE is ignored (no state change, no capture).
REQ-027 MEM/WB loads every edge: when stall_out=1 it loads a bubble (reg_write_out=0, mem_to_reg_out=0, rd=0, data=0).
REQ-028 When stall_out=0 MEM/WB loads mem_to_reg_in, reg_write_in, reg_rd_in, alu_result_in; read_data_out = dmem_rdata if BUSY AND dmem_ack, 0 on timeout, 0 for non-access instructions.
REQ-029 Completion latency: load issued in cycle N with ack at N+k (k>=1) -> MEM/WB valid after edge N+k; stall_out high cycles N..N+k-1.
REQ-030 Timeout completion sets mem_error_out=1; remains 1 until reset; instruction still retires with reg_write_in as given.
REQ-031 Non-access instruction: zero-latency pass-through, stall_out=0, dmem_req=0.

Reset
REQ-032 On reset=0: FSM=IDLE, counter=0, mem_error_out=0, all MEM/WB outputs 0; combinational outputs follow inputs.
REQ-033 Reset asserted during BUSY aborts access; dmem_req drops asynchronously unless IDLE-with-access is presented again.
REQ-034 First state change occurs on first rising edge after reset returns to 1.

Verification
REQ-035 ALU op: alu_result_in=0x0000_0010, reg_write_in=1, rd=5, no access -> next edge reg_rd_out=5, alu_data_mem_wb=0x10, stall_out=0 throughout.
REQ-036 Load addr 0x40, ack 3 cycles after request with rdata=0xDEAD_BEEF, mem_to_reg=1, rd=7 -> stall_out high 3 cycles, 3 bubbles, then read_data_out=0xDEAD_BEEF, alu_data_mem_wb=0xDEAD_BEEF.
REQ-037 Store addr 0x80 data 0x1234_5678 -> dmem_we=1, dmem_wdata=0x1234_5678 held stable until ack; reg_write_out=0 after completion.
REQ-038 TIMEOUT=4, load with no ack -> completes after 4 BUSY cycles, read_data_out=0, mem_error_out=1 and stays 1.
REQ-039 beq_instruction_in=1, flag_beq_in=1 -> pc_src_out=1 same cycle; flag_beq_in=0 -> 0.
REQ-040 reset=0 mid-BUSY (cycle 2 of 5) -> immediately state IDLE, all MEM/WB outputs 0, mem_error_out=0.

Source files
------------

// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
//
// MEM stage of a five-stage pipeline. It issues the load/store sitting in the
// EX/MEM register to a handshaked data memory, stalls the upstream pipeline
// until the memory acknowledges (or a wait counter expires), and loads the
// MEM/WB pipeline register. It also produces the branch-taken signal and the
// two forwarding sources (EX/MEM and MEM/WB) used by the EX-stage forwarding
// unit.
//
// Ports
//   clock, reset             : rising-edge clock, asynchronous active-low reset
//   *_in                     : EX/MEM pipeline register fields
//   dmem_req/we/addr/wdata   : data-memory request channel
//   dmem_rdata, dmem_ack     : data-memory response (ack is a 1-cycle pulse)
//   stall_out                : freezes PC, IF/ID, ID/EX and EX/MEM while high
//   pc_src_out               : branch taken (beq AND zero flag)
//   mem_to_reg_out, reg_write_out, read_data_out, alu_result_out, reg_rd_out
//                            : MEM/WB pipeline register
//   ex_mem_*, alu_ex_mem     : forwarding source taken from EX/MEM
//   mem_wb_*, alu_data_mem_wb: forwarding source taken from MEM/WB
//   mem_error_out            : sticky flag, set when an access timed out
// ---------------------------------------------------------------------------
module mem_access_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        mem_to_reg_in,
    input  logic        reg_write_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic        beq_instruction_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] mux2_result_in,
    input  logic [4:0]  reg_rd_in,
    input  logic        flag_beq_in,

    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,

    output logic        stall_out,
    output logic        pc_src_out,

    output logic        mem_to_reg_out,
    output logic        reg_write_out,
    output logic [31:0] read_data_out,
    output logic [31:0] alu_result_out,
    output logic [4:0]  reg_rd_out,

    output logic [4:0]  ex_mem_reg_rd,
    output logic        ex_mem_reg_write,
    output logic [31:0] alu_ex_mem,

    output logic [4:0]  mem_wb_reg_rd,
    output logic        mem_wb_reg_write,
    output logic [31:0] alu_data_mem_wb,

    output logic        mem_error_out
);

    localparam logic [7:0] TIMEOUT_VAL = 8'(TIMEOUT);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] wait_cnt;
    logic [7:0] wait_cnt_next;

    logic access;
    logic in_idle;
    logic in_busy;
    logic cnt_expired;
    logic ack_done;
    logic timeout_done;

    // A request with both read and write set is treated as a write simply
    // because dmem_we follows mem_write_in; access only needs either bit.
    assign access  = mem_read_in | mem_write_in;
    assign in_idle = (state == IDLE);
    assign in_busy = (state == BUSY);

    // wait_cnt holds the number of BUSY cycles elapsed including the current
    // one, so TIMEOUT is exactly the maximum number of cycles spent waiting.
    assign cnt_expired  = (wait_cnt == TIMEOUT_VAL);
    assign ack_done     = in_busy & dmem_ack;
    // An ack arriving in the same cycle the counter expires still counts as a
    // good completion, so the error path requires the ack to be absent.
    assign timeout_done = in_busy & ~dmem_ack & cnt_expired;

    // Branch resolution and EX/MEM forwarding are pure wiring.
    assign pc_src_out       = beq_instruction_in & flag_beq_in;
    assign ex_mem_reg_rd    = reg_rd_in;
    assign ex_mem_reg_write = reg_write_in;
    assign alu_ex_mem       = alu_result_in;

    // MEM/WB forwarding picks the value that write-back will commit.
    assign mem_wb_reg_rd    = reg_rd_out;
    assign mem_wb_reg_write = reg_write_out;
    assign alu_data_mem_wb  = mem_to_reg_out ? read_data_out : alu_result_out;

    // The address/data bus is driven straight from EX/MEM; it stays stable
    // during the access because stall_out freezes EX/MEM.
    assign dmem_addr  = alu_result_in;
    assign dmem_wdata = mux2_result_in;
    assign dmem_we    = mem_write_in;

    // State register and wait counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            wait_cnt <= 8'd0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // Next-state, counter and handshake outputs. The request is raised in the
    // same cycle the access is presented so a fast memory loses no cycle.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        dmem_req      = 1'b0;
        stall_out     = 1'b0;

        case (state)
            IDLE: begin
                wait_cnt_next = 8'd0;
                if (access) begin
                    dmem_req      = 1'b1;
                    stall_out     = 1'b1;
                    state_next    = BUSY;
                    wait_cnt_next = 8'd1;
                end
            end
            BUSY: begin
                dmem_req = 1'b1;
                if (dmem_ack || cnt_expired) begin
                    state_next    = IDLE;
                    wait_cnt_next = 8'd0;
                end else begin
                    stall_out = 1'b1;
                    if (!cnt_expired) begin
                        wait_cnt_next = wait_cnt + 8'd1;
                    end
                end
            end
            default: begin
                state_next    = IDLE;
                wait_cnt_next = 8'd0;
            end
        endcase
    end

    // MEM/WB register. A stalled cycle inserts a bubble so write-back never
    // sees a half-finished access; otherwise the EX/MEM fields advance and
    // read data is captured only from a real acknowledge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_to_reg_out <= 1'b0;
            reg_write_out  <= 1'b0;
            read_data_out  <= 32'd0;
            alu_result_out <= 32'd0;
            reg_rd_out     <= 5'd0;
        end else if (stall_out) begin
            mem_to_reg_out <= 1'b0;
            reg_write_out  <= 1'b0;
            read_data_out  <= 32'd0;
            alu_result_out <= 32'd0;
            reg_rd_out     <= 5'd0;
        end else begin
            mem_to_reg_out <= mem_to_reg_in;
            reg_write_out  <= reg_write_in;
            read_data_out  <= ack_done ? dmem_rdata : 32'd0;
            alu_result_out <= alu_result_in;
            reg_rd_out     <= reg_rd_in;
        end
    end

    // Sticky error flag; only reset clears it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_error_out <= 1'b0;
        end else if (timeout_done) begin
            mem_error_out <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_access_stage
//
// Self-checking bench for mem_access_stage (TIMEOUT = 4). Instructions are
// executed one at a time through exec_instr, which drives the EX/MEM fields,
// plays the data memory (ack after k cycles, or never when k = 0) and records
// what it saw. Each test task derives the expected outcome from the access
// rules (stall length = ack delay capped at TIMEOUT, error on no ack) and
// compares inline.
// ---------------------------------------------------------------------------
module tb_mem_access_stage;

    localparam int TMO = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_to_reg_in, reg_write_in, mem_read_in, mem_write_in;
    logic        beq_instruction_in, flag_beq_in;
    logic [31:0] alu_result_in, mux2_result_in;
    logic [4:0]  reg_rd_in;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_ack;
    logic        stall_out, pc_src_out;
    logic        mem_to_reg_out, reg_write_out;
    logic [31:0] read_data_out, alu_result_out;
    logic [4:0]  reg_rd_out;
    logic [4:0]  ex_mem_reg_rd;
    logic        ex_mem_reg_write;
    logic [31:0] alu_ex_mem;
    logic [4:0]  mem_wb_reg_rd;
    logic        mem_wb_reg_write;
    logic [31:0] alu_data_mem_wb;
    logic        mem_error_out;

    int checks = 0;
    int errors = 0;

    // Observations gathered by exec_instr for the calling test.
    int obs_stall, obs_req, obs_bubble_bad, obs_bus_bad, obs_pc_bad, obs_fwd_bad;
    int obs_hung;

    // Sticky error expected by the model.
    logic err_model;

    mem_access_stage #(.TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset),
        .mem_to_reg_in(mem_to_reg_in), .reg_write_in(reg_write_in),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .beq_instruction_in(beq_instruction_in),
        .alu_result_in(alu_result_in), .mux2_result_in(mux2_result_in),
        .reg_rd_in(reg_rd_in), .flag_beq_in(flag_beq_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .stall_out(stall_out), .pc_src_out(pc_src_out),
        .mem_to_reg_out(mem_to_reg_out), .reg_write_out(reg_write_out),
        .read_data_out(read_data_out), .alu_result_out(alu_result_out),
        .reg_rd_out(reg_rd_out),
        .ex_mem_reg_rd(ex_mem_reg_rd), .ex_mem_reg_write(ex_mem_reg_write),
        .alu_ex_mem(alu_ex_mem),
        .mem_wb_reg_rd(mem_wb_reg_rd), .mem_wb_reg_write(mem_wb_reg_write),
        .alu_data_mem_wb(alu_data_mem_wb),
        .mem_error_out(mem_error_out)
    );

    always #5 clock = ~clock;

    // Number of stalled cycles the model predicts for one instruction.
    function automatic int model_stall(input logic acc, input int k);
        if (!acc) return 0;
        if (k == 0 || k > TMO) return TMO;
        return k;
    endfunction

    function automatic logic model_timeout(input logic acc, input int k);
        return acc && (k == 0 || k > TMO);
    endfunction

    // Drive one instruction, act as the memory, and record observations.
    // For a non-access instruction a nonzero k pulses ack in its only cycle.
    task automatic exec_instr(input logic mtr, input logic rw, input logic mr,
                              input logic mw, input logic beq, input logic flag,
                              input logic [31:0] alu, input logic [31:0] wd,
                              input logic [4:0] rd, input int k,
                              input logic [31:0] rdata_v);
        logic acc;
        logic stalled;
        logic done;
        acc = mr | mw;
        mem_to_reg_in = mtr; reg_write_in = rw; mem_read_in = mr; mem_write_in = mw;
        beq_instruction_in = beq; flag_beq_in = flag;
        alu_result_in = alu; mux2_result_in = wd; reg_rd_in = rd;
        dmem_rdata = rdata_v;
        obs_stall = 0; obs_req = 0; obs_bubble_bad = 0; obs_bus_bad = 0;
        obs_pc_bad = 0; obs_fwd_bad = 0; obs_hung = 0;
        done = 1'b0;
        for (int c = 0; c < 300; c++) begin
            dmem_ack = (k > 0) && (acc ? (c == k) : (c == 0));
            @(negedge clock);
            if (stall_out) obs_stall++;
            if (dmem_req) obs_req++;
            if (dmem_addr !== alu || dmem_wdata !== wd || dmem_we !== mw) obs_bus_bad++;
            if (pc_src_out !== (beq & flag)) obs_pc_bad++;
            if (ex_mem_reg_rd !== rd || ex_mem_reg_write !== rw || alu_ex_mem !== alu)
                obs_fwd_bad++;
            stalled = stall_out;
            @(posedge clock);
            #1;
            if (!stalled) begin
                done = 1'b1;
                break;
            end
            if (reg_write_out !== 1'b0 || mem_to_reg_out !== 1'b0 || reg_rd_out !== 5'd0 ||
                read_data_out !== 32'd0 || alu_result_out !== 32'd0)
                obs_bubble_bad++;
        end
        dmem_ack = 1'b0;
        if (!done) obs_hung = 1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        mem_to_reg_in = 1'b0; reg_write_in = 1'b1; mem_read_in = 1'b1; mem_write_in = 1'b0;
        beq_instruction_in = 1'b1; flag_beq_in = 1'b1;
        alu_result_in = 32'h0000_0055; mux2_result_in = 32'hCAFE_0001; reg_rd_in = 5'd3;
        dmem_rdata = 32'd0; dmem_ack = 1'b0;
        #1;
        checks++;
        if (reg_write_out !== 1'b0 || mem_to_reg_out !== 1'b0 || reg_rd_out !== 5'd0 ||
            read_data_out !== 32'd0 || alu_result_out !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_mem_wb got rw=%b mtr=%b rd=%0d rdata=%h alu=%h required all 0",
                     reg_write_out, mem_to_reg_out, reg_rd_out, read_data_out, alu_result_out);
        end
        checks++;
        if (mem_error_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_error got %b required 0", mem_error_out);
        end
        checks++;
        if (pc_src_out !== 1'b1 || alu_ex_mem !== 32'h55 || ex_mem_reg_rd !== 5'd3 ||
            dmem_addr !== 32'h55 || dmem_wdata !== 32'hCAFE_0001) begin
            errors++;
            $display("[TB] FAIL reset_comb got pc=%b fwd=%h rd=%0d addr=%h wdata=%h required 1/55/3/55/cafe0001",
                     pc_src_out, alu_ex_mem, ex_mem_reg_rd, dmem_addr, dmem_wdata);
        end
        checks++;
        if (dmem_req !== 1'b1 || stall_out !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_idle_access got req=%b stall=%b required 1/1", dmem_req, stall_out);
        end
        mem_read_in = 1'b0;
        #6;
        reset = 1'b1;
        err_model = 1'b0;
    endtask

    task automatic test_alu_op();
        exec_instr(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 5'd5, 0, 32'h0);
        checks++;
        if (obs_stall !== 0 || obs_req !== 0) begin
            errors++;
            $display("[TB] FAIL alu_stall got stall=%0d req=%0d required 0/0", obs_stall, obs_req);
        end
        checks++;
        if (reg_rd_out !== 5'd5 || alu_data_mem_wb !== 32'h10 || mem_wb_reg_write !== 1'b1) begin
            errors++;
            $display("[TB] FAIL alu_retire got rd=%0d fwd=%h rw=%b required 5/10/1",
                     reg_rd_out, alu_data_mem_wb, mem_wb_reg_write);
        end
    endtask

    task automatic test_load();
        exec_instr(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'h0, 5'd7, 3, 32'hDEAD_BEEF);
        checks++;
        if (obs_stall !== 3 || obs_req !== 4 || obs_bubble_bad !== 0) begin
            errors++;
            $display("[TB] FAIL load_stall got stall=%0d req=%0d badbubble=%0d required 3/4/0",
                     obs_stall, obs_req, obs_bubble_bad);
        end
        checks++;
        if (read_data_out !== 32'hDEAD_BEEF || alu_data_mem_wb !== 32'hDEAD_BEEF ||
            reg_rd_out !== 5'd7 || mem_wb_reg_rd !== 5'd7) begin
            errors++;
            $display("[TB] FAIL load_data got rdata=%h fwd=%h rd=%0d required deadbeef/deadbeef/7",
                     read_data_out, alu_data_mem_wb, reg_rd_out);
        end
    endtask

    task automatic test_store();
        exec_instr(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0080, 32'h1234_5678, 5'd0, 2, 32'h0);
        checks++;
        if (obs_bus_bad !== 0 || obs_req !== 3 || obs_stall !== 2) begin
            errors++;
            $display("[TB] FAIL store_bus got busbad=%0d req=%0d stall=%0d required 0/3/2",
                     obs_bus_bad, obs_req, obs_stall);
        end
        checks++;
        if (reg_write_out !== 1'b0 || alu_result_out !== 32'h80) begin
            errors++;
            $display("[TB] FAIL store_retire got rw=%b alu=%h required 0/80", reg_write_out, alu_result_out);
        end
    endtask

    task automatic test_timeout();
        exec_instr(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 32'h0, 5'd9, 0, 32'hFFFF_FFFF);
        err_model = 1'b1;
        checks++;
        if (obs_stall !== TMO || obs_hung !== 0) begin
            errors++;
            $display("[TB] FAIL timeout_len got stall=%0d hung=%0d required %0d/0", obs_stall, obs_hung, TMO);
        end
        checks++;
        if (read_data_out !== 32'd0 || mem_error_out !== 1'b1 || reg_write_out !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeout_retire got rdata=%h err=%b rw=%b required 0/1/1",
                     read_data_out, mem_error_out, reg_write_out);
        end
        exec_instr(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h7, 32'h0, 5'd1, 0, 32'h0);
        checks++;
        if (mem_error_out !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeout_sticky got %b required 1", mem_error_out);
        end
    endtask

    task automatic test_branch();
        beq_instruction_in = 1'b1; flag_beq_in = 1'b1;
        #1;
        checks++;
        if (pc_src_out !== 1'b1) begin
            errors++;
            $display("[TB] FAIL branch_taken got %b required 1", pc_src_out);
        end
        flag_beq_in = 1'b0;
        #1;
        checks++;
        if (pc_src_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL branch_not_taken got %b required 0", pc_src_out);
        end
        beq_instruction_in = 1'b0;
    endtask

    task automatic test_random();
        logic        mtr, rw, mr, mw, beq, flag, acc, tmo;
        logic [31:0] alu, wd, rdv, exp_rd;
        logic [4:0]  rd;
        int          k, exp_stall;
        for (int n = 0; n < 120; n++) begin
            mtr = 1'($urandom); rw = 1'($urandom);
            mr = ($urandom_range(0, 2) == 0); mw = ($urandom_range(0, 2) == 0);
            beq = 1'($urandom); flag = 1'($urandom);
            alu = $urandom; wd = $urandom; rdv = $urandom; rd = 5'($urandom);
            k = $urandom_range(0, 6);
            acc = mr | mw;
            exp_stall = model_stall(acc, k);
            tmo = model_timeout(acc, k);
            exp_rd = (acc && !tmo) ? rdv : 32'd0;
            if (tmo) err_model = 1'b1;
            exec_instr(mtr, rw, mr, mw, beq, flag, alu, wd, rd, k, rdv);
            checks++;
            if (obs_stall !== exp_stall || obs_req !== (acc ? exp_stall + 1 : 0) || obs_hung !== 0) begin
                errors++;
                $display("[TB] FAIL rand_handshake n=%0d got stall=%0d req=%0d required stall=%0d req=%0d",
                         n, obs_stall, obs_req, exp_stall, acc ? exp_stall + 1 : 0);
            end
            checks++;
            if (obs_bubble_bad !== 0 || obs_bus_bad !== 0 || obs_pc_bad !== 0 || obs_fwd_bad !== 0) begin
                errors++;
                $display("[TB] FAIL rand_comb n=%0d got bubble=%0d bus=%0d pc=%0d fwd=%0d required all 0",
                         n, obs_bubble_bad, obs_bus_bad, obs_pc_bad, obs_fwd_bad);
            end
            checks++;
            if (reg_write_out !== rw || mem_to_reg_out !== mtr || reg_rd_out !== rd ||
                alu_result_out !== alu || read_data_out !== exp_rd) begin
                errors++;
                $display("[TB] FAIL rand_mem_wb n=%0d got rw=%b mtr=%b rd=%0d alu=%h rdata=%h required %b/%b/%0d/%h/%h",
                         n, reg_write_out, mem_to_reg_out, reg_rd_out, alu_result_out, read_data_out,
                         rw, mtr, rd, alu, exp_rd);
            end
            checks++;
            if (alu_data_mem_wb !== (mtr ? exp_rd : alu) || mem_error_out !== err_model) begin
                errors++;
                $display("[TB] FAIL rand_fwd_err n=%0d got fwd=%h err=%b required %h/%b",
                         n, alu_data_mem_wb, mem_error_out, mtr ? exp_rd : alu, err_model);
            end
        end
    endtask

    task automatic test_reset_mid_busy();
        // Make sure the error flag is set so its clearing is observable.
        exec_instr(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h44, 32'h0, 5'd2, 0, 32'h0);
        mem_to_reg_in = 1'b1; reg_write_in = 1'b1; mem_read_in = 1'b1; mem_write_in = 1'b0;
        alu_result_in = 32'h0000_0200; reg_rd_in = 5'd12; dmem_ack = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if (mem_error_out !== 1'b0 || reg_write_out !== 1'b0 || reg_rd_out !== 5'd0 ||
            alu_result_out !== 32'd0 || read_data_out !== 32'd0) begin
            errors++;
            $display("[TB] FAIL midbusy_clear got err=%b rw=%b rd=%0d alu=%h rdata=%h required all 0",
                     mem_error_out, reg_write_out, reg_rd_out, alu_result_out, read_data_out);
        end
        mem_read_in = 1'b0;
        #1;
        checks++;
        if (dmem_req !== 1'b0 || stall_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midbusy_req got req=%b stall=%b required 0/0", dmem_req, stall_out);
        end
        @(negedge clock);
        reset = 1'b1;
        err_model = 1'b0;
        exec_instr(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0033, 32'h0, 5'd4, 0, 32'h0);
        checks++;
        if (obs_stall !== 0 || reg_rd_out !== 5'd4 || alu_data_mem_wb !== 32'h33 || mem_error_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midbusy_recover got stall=%0d rd=%0d fwd=%h err=%b required 0/4/33/0",
                     obs_stall, reg_rd_out, alu_data_mem_wb, mem_error_out);
        end
    endtask

    initial begin
        err_model = 1'b0;
        test_reset();
        test_alu_op();
        test_load();
        test_store();
        test_branch();
        test_timeout();
        test_random();
        test_reset_mid_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
